// File: rtl/uart_wb_master8.sv
// Serial-to-Wishbone debug bridge: 8N1 commands 'W', 'R' and '?' issue single 8-bit classic cycles.
// Define WB_TIMEOUT_EN to add a bus-ack timeout that answers 0xEE.
module uart_wb_master8 #(
  parameter int unsigned BAUDRATE       = 115200,
  parameter int unsigned CLOCKFREQ      = 25000000,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  I_wb_clk,
  input  logic                  I_reset,
  input  logic                  I_rx,
  output logic                  O_tx,
  output logic [ADDR_WIDTH-1:0] O_wb_adr,
  output logic [7:0]            O_wb_dat,
  input  logic [7:0]            I_wb_dat,
  output logic                  O_wb_we,
  output logic                  O_wb_stb,
  output logic                  O_wb_cyc,
  input  logic                  I_wb_ack
);

  localparam int unsigned BaudClks  = CLOCKFREQ / BAUDRATE;
  // Start is accepted 3 clocks after the falling edge; first sample lands mid data bit 0.
  localparam int unsigned FirstWait = BaudClks + BaudClks / 2 - 4;
  localparam int unsigned CntW      = $clog2(BaudClks + BaudClks / 2);

  if (ADDR_WIDTH < 9 || ADDR_WIDTH > 16) begin : g_bad_addr_width
    $error("ADDR_WIDTH must be in 9..16");
  end
  if (TIMEOUT_CYCLES < 1 || BaudClks < 8) begin : g_bad_timing
    $error("TIMEOUT_CYCLES must be >= 1 and CLOCKFREQ/BAUDRATE >= 8");
  end

  typedef enum logic [1:0] {RxIdle, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {CmdIdle, CmdAhi, CmdAlo, CmdData, CmdBus, CmdResp, CmdWait} cmd_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic [1:0]      rx_low_q, rx_low_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid, rx_ferr;

  logic            tx_busy_q, tx_busy_d;
  logic            tx_q, tx_d;
  logic [8:0]      tx_shift_q, tx_shift_d;
  logic [3:0]      tx_left_q, tx_left_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic            tx_start, tx_done;

  cmd_state_e            cmd_state_q, cmd_state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [7:0]            dat_q, dat_d;
  logic [7:0]            resp_q, resp_d;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
`endif

  // Receiver
  always_comb begin
    rx_state_d = rx_state_q;
    rx_low_d   = rx_low_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (!I_rx) begin
          if (rx_low_q == 2'd3) begin
            rx_state_d = RxData;
            rx_cnt_d   = CntW'(FirstWait);
            rx_bit_d   = 3'd0;
            rx_low_d   = 2'd0;
          end else begin
            rx_low_d = rx_low_q + 2'd1;
          end
        end else begin
          rx_low_d = 2'd0;
        end
      end
      RxData: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {I_rx, rx_shift_q[7:1]};
          rx_cnt_d   = CntW'(BaudClks - 1);
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      RxStop: begin
        if (rx_cnt_q == '0) begin
          rx_valid   = I_rx;
          rx_ferr    = !I_rx;
          rx_state_d = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Transmitter: shift register holds remaining data bits plus the stop bit
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_d       = tx_q;
    tx_shift_d = tx_shift_q;
    tx_left_d  = tx_left_q;
    tx_cnt_d   = tx_cnt_q;
    tx_done    = 1'b0;
    if (!tx_busy_q) begin
      if (tx_start) begin
        tx_busy_d  = 1'b1;
        tx_d       = 1'b0;
        tx_shift_d = {1'b1, resp_q};
        tx_left_d  = 4'd9;
        tx_cnt_d   = CntW'(BaudClks - 1);
      end
    end else if (tx_cnt_q == '0) begin
      if (tx_left_q == 4'd0) begin
        tx_busy_d = 1'b0;
        tx_d      = 1'b1;
        tx_done   = 1'b1;
      end else begin
        tx_d       = tx_shift_q[0];
        tx_shift_d = {1'b0, tx_shift_q[8:1]};
        tx_left_d  = tx_left_q - 4'd1;
        tx_cnt_d   = CntW'(BaudClks - 1);
      end
    end else begin
      tx_cnt_d = tx_cnt_q - CntW'(1);
    end
  end

  // Command sequencer
  always_comb begin
    cmd_state_d = cmd_state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    resp_d      = resp_q;
    tx_start    = 1'b0;
`ifdef WB_TIMEOUT_EN
    to_cnt_d    = '0;
`endif
    unique case (cmd_state_q)
      CmdIdle: begin
        if (rx_valid) begin
          case (rx_shift_q)
            8'h57: begin we_d = 1'b1; cmd_state_d = CmdAhi; end
            8'h52: begin we_d = 1'b0; cmd_state_d = CmdAhi; end
            8'h3F: begin resp_d = 8'h42; cmd_state_d = CmdResp; end
            default: ;
          endcase
        end
      end
      CmdAhi: begin
        if (rx_ferr) begin
          cmd_state_d = CmdIdle;
        end else if (rx_valid) begin
          adr_d[ADDR_WIDTH-1:8] = rx_shift_q[ADDR_WIDTH-9:0];
          cmd_state_d           = CmdAlo;
        end
      end
      CmdAlo: begin
        if (rx_ferr) begin
          cmd_state_d = CmdIdle;
        end else if (rx_valid) begin
          adr_d[7:0]  = rx_shift_q;
          cmd_state_d = we_q ? CmdData : CmdBus;
        end
      end
      CmdData: begin
        if (rx_ferr) begin
          cmd_state_d = CmdIdle;
        end else if (rx_valid) begin
          dat_d       = rx_shift_q;
          cmd_state_d = CmdBus;
        end
      end
      CmdBus: begin
        if (I_wb_ack) begin
          resp_d      = we_q ? 8'hAA : I_wb_dat;
          cmd_state_d = CmdResp;
        end
`ifdef WB_TIMEOUT_EN
        else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          resp_d      = 8'hEE;
          cmd_state_d = CmdResp;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
`endif
      end
      CmdResp: begin
        tx_start    = 1'b1;
        cmd_state_d = CmdWait;
      end
      CmdWait: begin
        if (tx_done) cmd_state_d = CmdIdle;
      end
      default: cmd_state_d = CmdIdle;
    endcase
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      rx_state_q  <= RxIdle;
      rx_low_q    <= 2'd0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_busy_q   <= 1'b0;
      tx_q        <= 1'b1;
      tx_shift_q  <= 9'h1FF;
      tx_left_q   <= 4'd0;
      tx_cnt_q    <= '0;
      cmd_state_q <= CmdIdle;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= 8'h00;
      resp_q      <= 8'h00;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_low_q    <= rx_low_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      tx_busy_q   <= tx_busy_d;
      tx_q        <= tx_d;
      tx_shift_q  <= tx_shift_d;
      tx_left_q   <= tx_left_d;
      tx_cnt_q    <= tx_cnt_d;
      cmd_state_q <= cmd_state_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      resp_q      <= resp_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  always_ff @(posedge I_wb_clk) begin
    if (I_reset) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end
`endif

  assign O_tx     = tx_q;
  assign O_wb_stb = (cmd_state_q == CmdBus);
  assign O_wb_cyc = O_wb_stb;
  assign O_wb_we  = we_q & O_wb_stb;
  assign O_wb_adr = adr_q;
  assign O_wb_dat = dat_q;

endmodule

// File: tb/tb_uart_wb_master8.sv
// Self-checking bench for uart_wb_master8: host UART driver, memory slave, TX decoder,
// and a command-level reference model (expected bus transaction and response byte per command).
module tb_uart_wb_master8;

  logic        clk = 1'b0;
  logic        I_reset = 1'b1;
  logic        I_rx = 1'b1;
  logic        O_tx;
  logic [15:0] O_wb_adr;
  logic [7:0]  O_wb_dat;
  logic [7:0]  I_wb_dat = 8'h00;
  logic        O_wb_we, O_wb_stb, O_wb_cyc;
  logic        I_wb_ack = 1'b0;

  int tests_run = 0;
  int fails = 0;

  uart_wb_master8 #(
    .BAUDRATE      (100000),
    .CLOCKFREQ     (1000000),
    .ADDR_WIDTH    (16),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .I_wb_clk(clk),
    .I_reset (I_reset),
    .I_rx    (I_rx),
    .O_tx    (O_tx),
    .O_wb_adr(O_wb_adr),
    .O_wb_dat(O_wb_dat),
    .I_wb_dat(I_wb_dat),
    .O_wb_we (O_wb_we),
    .O_wb_stb(O_wb_stb),
    .O_wb_cyc(O_wb_cyc),
    .I_wb_ack(I_wb_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dat;
    int          len;
  } txn_t;

  txn_t       txn_q[$];
  logic [8:0] rsp_q[$];
  logic [7:0] slave_mem [0:65535];
  logic [7:0] model_mem [int];
  int         ack_delay = 0;
  bit         ack_en = 1'b1;
  int         stb_cyc = 0;
  int         stab_err = 0;
  int         cyc_err = 0;
  txn_t       cur;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return init_val(a);
  endfunction

  initial for (int i = 0; i < 65536; i++) slave_mem[i] = init_val(16'(i));

  // Memory slave plus bus monitor, acting on the falling edge
  always @(negedge clk) begin
    if (O_wb_stb === 1'b1) begin
      if (ack_en && stb_cyc == ack_delay) begin
        I_wb_ack = 1'b1;
        if (O_wb_we) slave_mem[O_wb_adr] = O_wb_dat;
        else         I_wb_dat = slave_mem[O_wb_adr];
      end else begin
        I_wb_ack = 1'b0;
        I_wb_dat = 8'($urandom);
      end
      if (stb_cyc == 0) begin
        cur.we  = O_wb_we;
        cur.adr = O_wb_adr;
        cur.dat = O_wb_dat;
      end else if (O_wb_we !== cur.we || O_wb_adr !== cur.adr || O_wb_dat !== cur.dat) begin
        stab_err++;
      end
      stb_cyc++;
    end else begin
      if (stb_cyc != 0) begin
        cur.len = stb_cyc;
        txn_q.push_back(cur);
      end
      stb_cyc  = 0;
      I_wb_ack = 1'b0;
    end
    if (O_wb_cyc !== O_wb_stb) cyc_err++;
  end

  // Host-side decoder of O_tx frames: {stop_ok, data}
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (O_tx === 1'b0) begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          d[i] = O_tx;
        end
        repeat (10) @(negedge clk);
        rsp_q.push_back({O_tx === 1'b1, d});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    I_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      I_rx = b[i];
      repeat (10) @(negedge clk);
    end
    I_rx = stop;
    repeat (10) @(negedge clk);
    I_rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_resp(output logic [8:0] r, output bit got);
    got = 1'b0;
    r   = 9'h0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (rsp_q.size() > 0) begin
        r   = rsp_q.pop_front();
        got = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    I_reset = 1'b1;
    I_rx    = 1'b1;
    repeat (3) @(negedge clk);
    I_reset = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++; if (O_tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", O_tx); end
    tests_run++; if (O_wb_stb !== 1'b0) begin fails++; $display("FAIL reset_stb: got %b want 0", O_wb_stb); end
    tests_run++; if (O_wb_cyc !== 1'b0) begin fails++; $display("FAIL reset_cyc: got %b want 0", O_wb_cyc); end
    tests_run++; if (O_wb_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", O_wb_we); end
    tests_run++; if (O_wb_adr !== 16'h0) begin fails++; $display("FAIL reset_adr: got %h want 0000", O_wb_adr); end
    tests_run++; if (O_wb_dat !== 8'h0) begin fails++; $display("FAIL reset_dat: got %h want 00", O_wb_dat); end
  endtask

  task automatic test_write;
    logic [8:0] r; bit got;
    txn_q.delete(); ack_delay = 3;
    send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'hA5, 1'b1);
    wait_resp(r, got);
    model_mem[int'(16'h1234)] = 8'hA5;
    tests_run++; if (!got || r !== 9'h1AA) begin fails++; $display("FAIL write_resp: got %h (rx %0d) want 1aa", r, got); end
    tests_run++; if (txn_q.size() != 1) begin fails++; $display("FAIL write_count: got %0d want 1", txn_q.size()); end
    if (txn_q.size() == 1) begin
      tests_run++; if (txn_q[0].we !== 1'b1) begin fails++; $display("FAIL write_we: got %b want 1", txn_q[0].we); end
      tests_run++; if (txn_q[0].adr !== 16'h1234) begin fails++; $display("FAIL write_adr: got %h want 1234", txn_q[0].adr); end
      tests_run++; if (txn_q[0].dat !== 8'hA5) begin fails++; $display("FAIL write_dat: got %h want a5", txn_q[0].dat); end
      tests_run++; if (txn_q[0].len != 4) begin fails++; $display("FAIL write_len: got %0d want 4", txn_q[0].len); end
    end
  endtask

  task automatic test_read_fast;
    logic [8:0] r; bit got;
    txn_q.delete(); ack_delay = 0;
    slave_mem[16'h0010] = 8'h5C; model_mem[int'(16'h0010)] = 8'h5C;
    send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    wait_resp(r, got);
    tests_run++; if (!got || r !== {1'b1, model_read(16'h0010)}) begin fails++; $display("FAIL read_resp: got %h want 15c", r); end
    tests_run++; if (txn_q.size() != 1) begin fails++; $display("FAIL read_count: got %0d want 1", txn_q.size()); end
    if (txn_q.size() == 1) begin
      tests_run++; if (txn_q[0].we !== 1'b0) begin fails++; $display("FAIL read_we: got %b want 0", txn_q[0].we); end
      tests_run++; if (txn_q[0].adr !== 16'h0010) begin fails++; $display("FAIL read_adr: got %h want 0010", txn_q[0].adr); end
      tests_run++; if (txn_q[0].len != 1) begin fails++; $display("FAIL read_len: got %0d want 1", txn_q[0].len); end
    end
  endtask

  task automatic test_ident;
    logic [8:0] r; bit got;
    txn_q.delete();
    send_byte(8'h3F, 1'b1);
    wait_resp(r, got);
    tests_run++; if (!got || r !== 9'h142) begin fails++; $display("FAIL ident_resp: got %h want 142", r); end
    send_byte(8'h00, 1'b1); send_byte(8'h3F, 1'b1);
    wait_resp(r, got);
    tests_run++; if (!got || r !== 9'h142) begin fails++; $display("FAIL ident_after_junk: got %h want 142", r); end
    tests_run++; if (txn_q.size() != 0) begin fails++; $display("FAIL ident_no_bus: got %0d want 0", txn_q.size()); end
  endtask

  task automatic test_framing;
    logic [8:0] r; bit got;
    txn_q.delete(); ack_delay = 1;
    send_byte(8'h57, 1'b0);
    repeat (200) @(negedge clk);
    send_byte(8'h52, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    wait_resp(r, got);
    tests_run++; if (!got || r !== {1'b1, model_read(16'h1234)}) begin fails++; $display("FAIL framing_resp: got %h want 1a5", r); end
    tests_run++; if (txn_q.size() != 1) begin fails++; $display("FAIL framing_count: got %0d want 1", txn_q.size()); end
    if (txn_q.size() == 1) begin
      tests_run++; if (txn_q[0].we !== 1'b0) begin fails++; $display("FAIL framing_we: got %b want 0", txn_q[0].we); end
    end
  endtask

  task automatic test_reset_mid_strobe;
    logic [8:0] r; bit got;
    txn_q.delete(); ack_en = 1'b0;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1); send_byte(8'h77, 1'b1);
    tests_run++; if (O_wb_stb !== 1'b1) begin fails++; $display("FAIL midrst_stb_before: got %b want 1", O_wb_stb); end
    I_reset = 1'b1;
    @(negedge clk);
    I_reset = 1'b0;
    tests_run++; if (O_wb_stb !== 1'b0 || O_wb_cyc !== 1'b0 || O_wb_we !== 1'b0)
      begin fails++; $display("FAIL midrst_bus: got stb/cyc/we %b%b%b want 000", O_wb_stb, O_wb_cyc, O_wb_we); end
    tests_run++; if (O_tx !== 1'b1) begin fails++; $display("FAIL midrst_tx: got %b want 1", O_tx); end
    repeat (300) @(negedge clk);
    tests_run++; if (rsp_q.size() != 0) begin fails++; $display("FAIL midrst_no_resp: got %0d want 0", rsp_q.size()); end
    rsp_q.delete(); txn_q.delete(); ack_en = 1'b1;
    send_byte(8'h3F, 1'b1);
    wait_resp(r, got);
    tests_run++; if (!got || r !== 9'h142) begin fails++; $display("FAIL midrst_ident: got %h want 142", r); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] r; bit got;
    txn_q.delete(); ack_delay = 2;
    send_byte(8'h3F, 1'b1);
    wait_resp(r, got);
    tests_run++; if (!got || r !== 9'h142) begin fails++; $display("FAIL b2b_first: got %h want 142", r); end
    send_byte(8'h52, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    wait_resp(r, got);
    tests_run++; if (!got || r !== {1'b1, model_read(16'h1234)}) begin fails++; $display("FAIL b2b_second: got %h want 1a5", r); end
  endtask

  task automatic test_random;
    logic [8:0] r; bit got;
    logic [15:0] adr; logic [7:0] dat, junk, exp;
    int kind;
    for (int n = 0; n < 12; n++) begin
      kind = int'($urandom_range(0, 2));
      adr = 16'h4000 | 16'($urandom_range(0, 7));
      dat = 8'($urandom);
      ack_delay = int'($urandom_range(0, 4));
      txn_q.delete();
      if ($urandom_range(0, 1) == 1) begin
        junk = 8'($urandom);
        if (junk == 8'h57 || junk == 8'h52 || junk == 8'h3F) junk = 8'h00;
        send_byte(junk, 1'b1);
      end
      if (kind == 2) begin
        send_byte(8'h3F, 1'b1);
        exp = 8'h42;
      end else begin
        send_byte(kind == 0 ? 8'h57 : 8'h52, 1'b1);
        send_byte(adr[15:8], 1'b1);
        send_byte(adr[7:0], 1'b1);
        if (kind == 0) send_byte(dat, 1'b1);
        exp = (kind == 0) ? 8'hAA : model_read(adr);
      end
      wait_resp(r, got);
      if (kind == 0) model_mem[int'(adr)] = dat;
      tests_run++; if (!got || r !== {1'b1, exp}) begin fails++; $display("FAIL rnd%0d_resp: got %h want %h", n, r, {1'b1, exp}); end
      tests_run++; if (txn_q.size() != (kind == 2 ? 0 : 1))
        begin fails++; $display("FAIL rnd%0d_count: got %0d kind %0d", n, txn_q.size(), kind); end
      if (kind != 2 && txn_q.size() == 1) begin
        tests_run++;
        if (txn_q[0].we !== (kind == 0) || txn_q[0].adr !== adr || txn_q[0].len != ack_delay + 1 ||
            (kind == 0 && txn_q[0].dat !== dat)) begin
          fails++;
          $display("FAIL rnd%0d_txn: got we=%b adr=%h dat=%h len=%0d want we=%b adr=%h dat=%h len=%0d",
                   n, txn_q[0].we, txn_q[0].adr, txn_q[0].dat, txn_q[0].len, kind == 0, adr, dat, ack_delay + 1);
        end
      end
    end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout;
    logic [8:0] r; bit got;
    txn_q.delete(); ack_en = 1'b0;
    send_byte(8'h52, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    wait_resp(r, got);
    ack_en = 1'b1;
    tests_run++; if (!got || r !== 9'h1EE) begin fails++; $display("FAIL timeout_resp: got %h want 1ee", r); end
    tests_run++; if (txn_q.size() != 1 || txn_q[0].len != 20)
      begin fails++; $display("FAIL timeout_len: got %0d txns want one of 20 clocks", txn_q.size()); end
  endtask
`endif

  task automatic test_protocol;
    tests_run++; if (stab_err != 0) begin fails++; $display("FAIL bus_stable: got %0d changes want 0", stab_err); end
    tests_run++; if (cyc_err != 0) begin fails++; $display("FAIL cyc_eq_stb: got %0d mismatches want 0", cyc_err); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_fast;
    test_ident;
    test_framing;
    test_reset_mid_strobe;
    test_back_to_back;
    test_random;
`ifdef WB_TIMEOUT_EN
    test_timeout;
`endif
    test_protocol;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
